// File: rtl/add_pkg.sv
// Shared definitions for the add operand loader: default width, loader states and
// a bit-index to add-port-name lookup for benches and debug.
package add_pkg;

  localparam int unsigned VEC_W_DEF = 25;

  typedef enum logic {
    StShift,
    StPresent
  } loader_state_e;

  // vec[VEC_W_DEF-1] drives port 'a', vec[0] drives port 'y'; returns the ASCII port letter.
  function automatic logic [7:0] port_name(input int unsigned idx);
    return 8'(32'd97 + (VEC_W_DEF - 1 - idx));
  endfunction

endpackage

// File: rtl/add_vec_sipo.sv
// Serial-in parallel-out shift register with bit counter; sof restarts the frame and
// last pulses combinationally on the accept that completes a full vector.
module add_vec_sipo
  import add_pkg::*;
#(
  parameter int unsigned VEC_W = VEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             sof,
  input  logic             data,
  output logic [VEC_W-1:0] shift_next,
  output logic             last
);

  localparam int unsigned CntW = $clog2(VEC_W + 1);

  logic [VEC_W-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;

  always_comb begin
    shift_next = sr_q;
    cnt_d      = cnt_q;
    last       = 1'b0;
    if (accept) begin
      if (sof) begin
        shift_next    = '0;
        shift_next[0] = data;
        cnt_d         = CntW'(1);
      end else begin
        shift_next = (sr_q << 1) | VEC_W'(data);
        cnt_d      = cnt_q + CntW'(1);
      end
      // A completed vector also covers sof on the only bit when VEC_W is 1.
      if (cnt_d == CntW'(VEC_W)) begin
        last  = 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= shift_next;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/add_vec_loader.sv
// Framed serial operand loader for the add netlist: assembles VEC_W bits, presents them
// with on held for HOLD_CYCLES, and counts completed frames.
module add_vec_loader
  import add_pkg::*;
#(
  parameter int unsigned VEC_W       = VEC_W_DEF,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sin_valid,
  input  logic             sin_sof,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [VEC_W-1:0] vec,
  output logic             on,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  loader_state_e    state_q;
  logic [HoldW-1:0] hold_q;
  logic             accept;
  logic             last;
  logic [VEC_W-1:0] shift_next;

  // Gated by rst so nothing is offered while reset is held.
  assign sin_ready = run & rst & (state_q == StShift);
  assign accept    = sin_valid & sin_ready;

  add_vec_sipo #(
    .VEC_W(VEC_W)
  ) u_sipo (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .sof       (sin_sof),
    .data      (sin_data),
    .shift_next(shift_next),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StShift;
      hold_q    <= '0;
      vec       <= '0;
      on        <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state_q)
        StShift: begin
          if (last) begin
            vec       <= shift_next;
            on        <= 1'b1;
            frame_cnt <= frame_cnt + CNT_W'(1);
            hold_q    <= HoldW'(1);
            state_q   <= StPresent;
          end
        end
        StPresent: begin
          if (hold_q == HoldW'(HOLD_CYCLES)) begin
            on      <= 1'b0;
            state_q <= StShift;
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        default: state_q <= StShift;
      endcase
    end
  end

endmodule
